// File: rtl/cmp_scheduler.sv
// cmp_scheduler: one unsigned less-than / greater-than compare datapath shared by two
// requesters through round-robin arbitration and a req/ack handshake.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   i_req0/i_req1         requests, held by the requester until its ack
//   i_op0/i_op1           0 = a<b, 1 = a>b
//   i_a0/i_b0, i_a1/i_b1  operands, sampled on the grant edge
//   o_ack0/o_ack1         one-cycle pulse while o_result holds the owner's result
//   o_result              compare result (0/1) zero-extended to WIDTH
//   o_busy                high in EXEC and DONE
//   o_owner               requester currently/last served
//
// Flow: IDLE (grant, latch operands) -> EXEC (compare, register result) -> DONE (ack) -> IDLE.
module cmp_scheduler #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req0,
  input  logic             i_op0,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic             i_req1,
  input  logic             i_op1,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy,
  output logic             o_owner
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic             ptr_q;   // requester favoured when both request
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             res_q;

  logic             any_req;
  logic             winner;
  logic             win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic             cmp_res;

  // Arbitration: a lone requester wins outright; on contention the pointer decides.
  always_comb begin
    any_req = i_req0 | i_req1;
    winner  = (i_req0 & i_req1) ? ptr_q : i_req1;
    win_op  = winner ? i_op1 : i_op0;
    win_a   = winner ? i_a1 : i_a0;
    win_b   = winner ? i_b1 : i_b0;
  end

  // Extra zero MSB keeps the compare strictly unsigned regardless of operand top bit.
  always_comb begin
    a_ext   = {1'b0, a_q};
    b_ext   = {1'b0, b_q};
    cmp_res = op_q ? (a_ext > b_ext) : (a_ext < b_ext);
  end

  assign o_result = {{(WIDTH-1){1'b0}}, res_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= 1'b0;
      o_ack0  <= 1'b0;
      o_ack1  <= 1'b0;
      o_busy  <= 1'b0;
      o_owner <= 1'b0;
    end else begin
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            op_q    <= win_op;
            a_q     <= win_a;
            b_q     <= win_b;
            o_owner <= winner;
            ptr_q   <= ~winner;
            o_busy  <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          res_q   <= cmp_res;
          o_ack0  <= ~o_owner;
          o_ack1  <= o_owner;
          state_q <= StDone;
        end
        StDone: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
